// File: rtl/lsu_pkg.sv
// Shared types and constants for the load/store unit.
// Contents: FSM state encoding, access-size encodings, default memory geometry.
// No ports; imported by load_store_unit and lsu_load_align.
package lsu_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  localparam logic SIZE_BYTE = 1'b0;
  localparam logic SIZE_WORD = 1'b1;

  localparam int MEM_WORDS_DEFAULT = 11040;
  localparam int MEM_BYTES         = MEM_WORDS_DEFAULT * 4;

endpackage

// File: rtl/lsu_load_align.sv
// Load data alignment: picks the addressed byte lane out of the memory word and
// sign/zero-extends it, or passes the whole word through for word loads.
// Ports: word_i (raw memory word), size_i, uns_i, lane_i (addr[1:0]) -> data_o.
module lsu_load_align
  import lsu_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [DATA_W-1:0] word_i,
  input  logic              size_i,
  input  logic              uns_i,
  input  logic [1:0]        lane_i,
  output logic [DATA_W-1:0] data_o
);

  logic [7:0] byte_v;
  logic       fill_v;

  always_comb begin
    byte_v = word_i[8*lane_i +: 8];
    fill_v = uns_i ? 1'b0 : byte_v[7];
    data_o = word_i;
    if (size_i == SIZE_BYTE) begin
      data_o = {{(DATA_W-8){fill_v}}, byte_v};
    end
  end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: sole initiator on the data-memory (memoria) port. Accepts one
// request in IDLE, drives memoria for one ACCESS cycle, then holds the response in
// RESP until rsp_ready. Ports: clock/reset, req_* (execute side), rsp_* (result),
// mem_* (memoria), cnt_loads/cnt_stores (saturating completion counters).
// Build option: MISALIGN_TRAP_EN makes misaligned word accesses return rsp_err.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int MEM_WORDS = MEM_WORDS_DEFAULT,
  parameter int CNT_W     = 16
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic              req_size,
  input  logic              req_uns,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic [ADDR_W-1:0] mem_dir,
  output logic              mem_width,
  output logic              mem_wen,
  output logic [DATA_W-1:0] mem_in,
  input  logic [DATA_W-1:0] mem_out,
  output logic [CNT_W-1:0]  cnt_loads,
  output logic [CNT_W-1:0]  cnt_stores
);

  localparam longint unsigned MEM_LIMIT_L = longint'(MEM_WORDS) * 4;
  localparam logic [ADDR_W:0] MEM_LIMIT   = (ADDR_W+1)'(MEM_LIMIT_L);

  state_t state_q, state_d;

  logic              req_we_q, req_size_q, req_uns_q, req_err_q;
  logic [1:0]        req_lane_q;
  logic [ADDR_W-1:0] mem_dir_q;
  logic              mem_width_q;
  logic [DATA_W-1:0] mem_in_q;
  logic [DATA_W-1:0] rsp_rdata_q;
  logic              rsp_err_q;
  logic [CNT_W-1:0]  cnt_loads_q, cnt_stores_q;

  logic              accept;
  logic [ADDR_W-1:0] addr_eff;
  logic              err_d;
  logic [DATA_W-1:0] load_data;

  // Word accesses always target the containing word; low address bits only
  // matter for byte lanes (and for the optional misalignment trap).
  assign addr_eff = (req_size == SIZE_WORD) ? {req_addr[ADDR_W-1:2], 2'b00} : req_addr;

  always_comb begin
    err_d = ({1'b0, addr_eff} >= MEM_LIMIT);
`ifdef MISALIGN_TRAP_EN
    if ((req_size == SIZE_WORD) && (req_addr[1:0] != 2'b00)) begin
      err_d = 1'b1;
    end
`endif
  end

  always_comb begin
    state_d   = state_q;
    req_ready = (state_q == IDLE);
    rsp_valid = (state_q == RESP);
    // Derived from the state register so reset kills a write strobe immediately.
    mem_wen   = (state_q == ACCESS) && req_we_q && !req_err_q;
    accept    = 1'b0;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          accept  = 1'b1;
          state_d = ACCESS;
        end
      end
      ACCESS:  state_d = RESP;
      RESP:    if (rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  lsu_load_align #(.DATA_W(DATA_W)) u_align (
    .word_i (mem_out),
    .size_i (req_size_q),
    .uns_i  (req_uns_q),
    .lane_i (req_lane_q),
    .data_o (load_data)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      req_we_q     <= 1'b0;
      req_size_q   <= SIZE_BYTE;
      req_uns_q    <= 1'b0;
      req_err_q    <= 1'b0;
      req_lane_q   <= 2'b00;
      mem_dir_q    <= '0;
      mem_width_q  <= 1'b0;
      mem_in_q     <= '0;
      rsp_rdata_q  <= '0;
      rsp_err_q    <= 1'b0;
      cnt_loads_q  <= '0;
      cnt_stores_q <= '0;
    end else begin
      state_q <= state_d;
      // mem_* registers load on accept so they are valid throughout ACCESS and
      // simply hold afterwards.
      if (accept) begin
        req_we_q    <= req_we;
        req_size_q  <= req_size;
        req_uns_q   <= req_uns;
        req_err_q   <= err_d;
        req_lane_q  <= req_addr[1:0];
        mem_dir_q   <= addr_eff;
        mem_width_q <= req_size;
        mem_in_q    <= (req_size == SIZE_WORD) ? req_wdata
                                               : {{(DATA_W-8){1'b0}}, req_wdata[7:0]};
      end
      if (state_q == ACCESS) begin
        rsp_rdata_q <= (req_we_q || req_err_q) ? '0 : load_data;
        rsp_err_q   <= req_err_q;
      end
      if ((state_q == RESP) && rsp_ready && !req_err_q) begin
        if (req_we_q) begin
          if (cnt_stores_q != '1) cnt_stores_q <= cnt_stores_q + 1'b1;
        end else begin
          if (cnt_loads_q != '1) cnt_loads_q <= cnt_loads_q + 1'b1;
        end
      end
    end
  end

  assign mem_dir    = mem_dir_q;
  assign mem_width  = mem_width_q;
  assign mem_in     = mem_in_q;
  assign rsp_rdata  = rsp_rdata_q;
  assign rsp_err    = rsp_err_q;
  assign cnt_loads  = cnt_loads_q;
  assign cnt_stores = cnt_stores_q;

endmodule
